serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Receive side of the 10-bit serial character link. Stream format: idle high; each frame is start bit (0), data d7..d0 MSB first, then stop bit (1).
- Block oversamples the line, detects and validates start bits, and shifts the data bits into a serial-in/parallel-out register.
- Checks the stop bit and presents the completed byte in a holding register with a ready/read handshake to the processor bus.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; even value, >= 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; synchronous, active-high.
- sample_tick  input  1  one-clk enable pulse at OVERSAMPLE x bit rate; all bit timing advances only on this pulse.
- serial_in  input  1  asynchronous serial line, idle high.
- read  input  1  one-clk strobe; consumer takes data_out.
- data_out  output  DATA_BITS  holding register, last good character.
- char_ready  output  1  level; unread character in data_out.
- overrun  output  1  sticky; a good character overwrote an unread one.
- framing_error  output  1  one-clk pulse; stop bit sampled 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: data_out=0, char_ready=0, overrun=0, framing_error=0, busy=0, state=IDLE, counters=0, synchronizer=2'b11.
- Reset mid-frame aborts the frame with no char_ready and no error.
- serial_in passes a 2-FF synchronizer every clk. All decisions use the synchronized value rx_s.
- Tick counter tc counts sample_tick pulses. Bit counter bc is 0..DATA_BITS-1.
- IDLE: on a tick with rx_s=0, go to START with tc=0.
- START: count ticks. At the tick where tc=OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: go to DATA with tc=0, bc=0.
  - rx_s=1: glitch; return to IDLE with no outputs.
- DATA: on each tick where tc=OVERSAMPLE-1 (mid bit), shift rx_s into the shift register LSB and set tc=0. Other ticks increment tc.
  - The first data bit received ends in bit DATA_BITS-1.
  - After the sample with bc=DATA_BITS-1, go to STOP with tc=0. Otherwise increment bc.
- STOP: at the tick where tc=OVERSAMPLE-1:
  - rx_s=1: data_out<=shift register, char_ready<=1, go to IDLE.
  - rx_s=0: framing_error pulse for one clk. Data is discarded; data_out, char_ready and overrun are unchanged. Go to WAIT_HIGH.
- WAIT_HIGH: on any tick with rx_s=1, go to IDLE. This prevents a held-low line (break) from retriggering START.
- Latency: char_ready rises on the clk after the sample_tick that samples the mid stop bit.
- Handshake:
  - read with char_ready=1 clears char_ready and overrun on the next clk.
  - read with char_ready=0 is ignored.
- Overrun: a good frame completing while char_ready=1 and read=0 overwrites data_out, keeps char_ready=1, and sets overrun=1.
- Simultaneous read and good-frame completion in the same clk: the new character wins. data_out is new, char_ready=1, overrun=0.
- No tick in a clk means state and counters hold. The synchronizer still runs.

Test Plan:
- OVERSAMPLE=16, sample_tick=1 every clk. Drive frame 0,1,0,1,0,0,1,0,1,1 (d=0xA5), 16 clk per bit -> char_ready rises exactly 1 clk after the mid stop-bit sample (plus 2 synchronizer clk) and data_out=0xA5. read -> char_ready=0 next clk.
- Low pulse of 5 clk on an idle line -> returns to IDLE; no char_ready, no framing_error; busy high for no more than 8+2 clk.
- Frame 0x3C with stop bit driven 0, then line held low for 40 clk, then high -> one framing_error pulse; data_out and char_ready unchanged; no new START until the line returns high.
- Send 0x11 unread, then 0x22 -> data_out=0x22, char_ready=1, overrun=1. read -> both clear.
- Time read on the exact completion clk of a second frame 0x7E -> data_out=0x7E, char_ready=1, overrun=0.
- Assert reset mid-DATA (after 4 bits), release, then send 0x81 -> no output from the aborted frame; data_out=0x81. Repeat with sample_tick every 3rd clk -> same results.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receive side of the 10-bit serial character link.
// Oversamples the synchronized line, validates the start bit, shifts in
// DATA_BITS data bits MSB first, checks the stop bit and hands the byte
// to the bus through a holding register with a ready/read handshake.
module serial_frame_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 serial_in,
    input  logic                 read,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 char_ready,
    output logic                 overrun,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int TC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TC_W-1:0] TC_MID_START = TC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TC_W-1:0] TC_LAST      = TC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST      = BC_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [TC_W-1:0]       tc_q, tc_d;
    logic [BC_W-1:0]       bc_q, bc_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_out_q, data_out_d;
    logic                  char_ready_q, char_ready_d;
    logic                  overrun_q, overrun_d;
    logic                  framing_error_q, framing_error_d;
    logic                  busy_q, busy_d;
    logic                  good_s;
    logic                  rx_s;

    assign rx_s          = sync_q[1];
    assign data_out      = data_out_q;
    assign char_ready    = char_ready_q;
    assign overrun       = overrun_q;
    assign framing_error = framing_error_q;
    assign busy          = busy_q;

    // Frame FSM: bit timing, data shifting and stop-bit check, advancing only on sample_tick.
    always_comb begin
        sync_d          = {sync_q[0], serial_in};
        state_d         = state_q;
        tc_d            = tc_q;
        bc_d            = bc_q;
        shift_d         = shift_q;
        good_s          = 1'b0;
        framing_error_d = 1'b0;
        if (sample_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        tc_d    = {TC_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tc_q == TC_MID_START) begin
                        tc_d = {TC_W{1'b0}};
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            bc_d    = {BC_W{1'b0}};
                        end else begin
                            // A start bit gone by mid-bit was a glitch.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tc_d = tc_q + {{(TC_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DATA: begin
                    if (tc_q == TC_LAST) begin
                        tc_d    = {TC_W{1'b0}};
                        shift_d = {shift_q[DATA_BITS-2:0], rx_s};
                        if (bc_q == BC_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bc_d = bc_q + {{(BC_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        tc_d = tc_q + {{(TC_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_STOP: begin
                    if (tc_q == TC_LAST) begin
                        tc_d = {TC_W{1'b0}};
                        if (rx_s) begin
                            good_s  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            // Wait for the line to go high so a break cannot retrigger START.
                            framing_error_d = 1'b1;
                            state_d         = ST_WAIT_HIGH;
                        end
                    end else begin
                        tc_d = tc_q + {{(TC_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tc_d    = {TC_W{1'b0}};
                    bc_d    = {BC_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Holding register and handshake: a completing character beats a same-cycle read.
    always_comb begin
        data_out_d   = data_out_q;
        char_ready_d = char_ready_q;
        overrun_d    = overrun_q;
        if (good_s) begin
            data_out_d   = shift_q;
            char_ready_d = 1'b1;
            overrun_d    = char_ready_q & ~read;
        end else if (read && char_ready_q) begin
            char_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            char_ready_d = char_ready_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, synchronizer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            sync_q          <= 2'b11;
            tc_q            <= {TC_W{1'b0}};
            bc_q            <= {BC_W{1'b0}};
            shift_q         <= {DATA_BITS{1'b0}};
            data_out_q      <= {DATA_BITS{1'b0}};
            char_ready_q    <= 1'b0;
            overrun_q       <= 1'b0;
            framing_error_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            tc_q            <= tc_d;
            bc_q            <= bc_d;
            shift_q         <= shift_d;
            data_out_q      <= data_out_d;
            char_ready_q    <= char_ready_d;
            overrun_q       <= overrun_d;
            framing_error_q <= framing_error_d;
            busy_q          <= busy_d;
        end
    end

endmodule
